dmem_resp: RTL and testbench



---
 rtl/dmem_resp.sv | 129 ++++++++++++
 tb/tb_dmem_resp.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_resp.sv
// Data-memory responder: validates a load/store request, performs it after
// WAIT_CYCLES wait states and returns extended load data with a valid pulse.
module dmem_resp #(
  parameter int DEPTH_WORDS = 4096,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs_i,
  input  logic        we_i,
  input  logic [3:0]  wem_i,
  input  logic [31:0] din_i,
  input  logic [31:0] addr_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] rdata_o,
  output logic        rvalid_o,
  output logic        hold_o,
  output logic        err_o
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        r_state;
  logic [2:0]    r_cnt;
  logic          r_we;
  logic [3:0]    r_wem;
  logic [31:0]   r_din;
  logic [AW+1:0] r_addr;
  logic [2:0]    r_f3;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_half, w_word, w_f3_ok, w_align_ok, w_range_ok, w_ok;
  logic          w_open, w_req, w_acc, w_rej;
  logic          w_exec_new, w_exec_pend, w_exec;
  logic          w_x_we;
  logic [3:0]    w_x_wem;
  logic [31:0]   w_x_din;
  logic [AW+1:0] w_x_addr;
  logic [2:0]    w_x_f3;
  logic [31:0]   w_rword, w_ld;
  logic [7:0]    w_b;
  logic [15:0]   w_h;

  // Request legality
  assign w_half     = (funct3_i[1:0] == 2'b01);
  assign w_word     = (funct3_i[1:0] == 2'b10);
  assign w_f3_ok    = we_i ? (funct3_i inside {3'b000, 3'b001, 3'b010})
                           : (funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  assign w_align_ok = !(w_half && addr_i[0]) && !(w_word && (addr_i[1:0] != 2'b00));
  assign w_range_ok = ({2'b00, addr_i[31:2]} < 32'(DEPTH_WORDS));
  assign w_ok       = w_f3_ok && w_align_ok && w_range_ok;

  // The last BUSY cycle (counter at 0) already accepts the next request, so the
  // requester sees exactly WAIT_CYCLES hold cycles per access.
  assign w_open = (r_state == IDLE) || (r_cnt == 3'd0);
  assign w_req  = cs_i && w_open && !rst;
  assign w_acc  = w_req && w_ok;
  assign w_rej  = w_req && !w_ok;

  assign w_exec_new  = w_acc && (WAIT_CYCLES == 0);
  assign w_exec_pend = (r_state == BUSY) && (r_cnt == 3'd0) && !rst;
  assign w_exec      = w_exec_new || w_exec_pend;

  assign hold_o = ((r_state == BUSY) && (r_cnt != 3'd0) && !rst) || (w_acc && (WAIT_CYCLES > 0));

  // A pending access always comes from the latched copy; zero-wait uses live inputs
  assign w_x_we   = (r_state == BUSY) ? r_we   : we_i;
  assign w_x_wem  = (r_state == BUSY) ? r_wem  : wem_i;
  assign w_x_din  = (r_state == BUSY) ? r_din  : din_i;
  assign w_x_addr = (r_state == BUSY) ? r_addr : addr_i[AW+1:0];
  assign w_x_f3   = (r_state == BUSY) ? r_f3   : funct3_i;

  assign w_rword = r_mem[w_x_addr[AW+1:2]];
  assign w_h     = w_x_addr[1] ? w_rword[31:16] : w_rword[15:0];
  assign w_b     = w_x_addr[0] ? w_h[15:8] : w_h[7:0];

  always_comb begin
    w_ld = w_rword;
    case (w_x_f3)
      3'b000:  w_ld = {{24{w_b[7]}}, w_b};
      3'b100:  w_ld = {24'd0, w_b};
      3'b001:  w_ld = {{16{w_h[15]}}, w_h};
      3'b101:  w_ld = {16'd0, w_h};
      default: w_ld = w_rword;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= 3'd0;
      r_we     <= 1'b0;
      r_wem    <= 4'd0;
      r_din    <= 32'd0;
      r_addr   <= '0;
      r_f3     <= 3'd0;
      rdata_o  <= 32'd0;
      rvalid_o <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      rvalid_o <= w_exec && !w_x_we;
      if (w_exec && !w_x_we) rdata_o <= w_ld;
      err_o <= w_rej;
      if (r_state == BUSY) begin
        if (r_cnt != 3'd0) r_cnt <= r_cnt - 3'd1;
        else               r_state <= IDLE;
      end
      if (w_req) begin
        r_we   <= we_i;
        r_wem  <= wem_i;
        r_din  <= din_i;
        r_addr <= addr_i[AW+1:0];
        r_f3   <= funct3_i;
      end
      if (w_acc && (WAIT_CYCLES > 0)) begin
        r_state <= BUSY;
        r_cnt   <= 3'(WAIT_CYCLES - 1);
      end
    end
  end

  // RAM is deliberately not reset
  always_ff @(posedge clk) begin
    if (w_exec && w_x_we)
      for (int b = 0; b < 4; b++)
        if (w_x_wem[b]) r_mem[w_x_addr[AW+1:2]][8*b +: 8] <= w_x_din[8*b +: 8];
  end
endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: zero-wait and three-wait instances against a
// transaction-level model with a byte-addressed memory.
module tb_dmem_resp;
  localparam int D0 = 4096;
  localparam int D3 = 256;

  logic        clk = 1'b0;
  logic        rst, cs0, cs3, we;
  logic [3:0]  wem;
  logic [31:0] din, addr;
  logic [2:0]  f3;
  logic [31:0] rd0, rd3;
  logic        rv0, rv3, h0, h3, e0, e3;
  logic [34:0] obs;

  always #5 clk = ~clk;

  dmem_resp #(.DEPTH_WORDS(D0), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst(rst), .cs_i(cs0), .we_i(we), .wem_i(wem), .din_i(din),
    .addr_i(addr), .funct3_i(f3), .rdata_o(rd0), .rvalid_o(rv0), .hold_o(h0), .err_o(e0));
  dmem_resp #(.DEPTH_WORDS(D3), .WAIT_CYCLES(3)) u3 (
    .clk(clk), .rst(rst), .cs_i(cs3), .we_i(we), .wem_i(wem), .din_i(din),
    .addr_i(addr), .funct3_i(f3), .rdata_o(rd3), .rvalid_o(rv3), .hold_o(h3), .err_o(e3));

  int sel, cyc, checks, errors;
  assign obs = (sel != 0) ? {h3, e3, rv3, rd3} : {h0, e0, rv0, rd0};

  typedef struct packed {
    bit r; bit c; bit w; bit [3:0] m; bit [31:0] d; bit [31:0] a; bit [2:0] f;
    bit kc; bit [31:0] kv; bit ke; bit kh; bit kz;
  } op_t;

  // Reference model: byte memories, one outstanding access, next-cycle outputs
  bit [7:0]  m0 [bit [31:0]];
  bit [7:0]  m3 [bit [31:0]];
  bit        pend;
  int        pexec;
  op_t       pop;
  bit        nxt_err, nxt_rv, rd_upd, nxt_known, cur_err, cur_rv, cur_known, exp_hold;
  bit [31:0] nxt_rd, cur_rd;
  logic [34:0] exp_o, care;

  function automatic op_t OP(bit r, bit c, bit w, bit [3:0] m, bit [31:0] d, bit [31:0] a, bit [2:0] f);
    op_t o = '0;
    o.r = r; o.c = c; o.w = w; o.m = m; o.d = d; o.a = a; o.f = f;
    return o;
  endfunction
  function automatic op_t ST(bit [31:0] a, bit [31:0] d, bit [3:0] m, bit [2:0] f);
    return OP(0, 1, 1, m, d, a, f);
  endfunction
  function automatic op_t LD(bit [31:0] a, bit [2:0] f);
    return OP(0, 1, 0, 4'h0, 32'h0, a, f);
  endfunction
  function automatic op_t NOP();
    return OP(0, 0, 0, 4'h0, 32'h0, 32'h0, 3'h0);
  endfunction
  function automatic op_t KC(op_t o, bit [31:0] v); o.kc = 1; o.kv = v; return o; endfunction
  function automatic op_t KE(op_t o); o.ke = 1; return o; endfunction
  function automatic op_t KH(op_t o); o.kh = 1; return o; endfunction
  function automatic op_t KZ(op_t o); o.kz = 1; return o; endfunction

  function automatic bit mhas(bit [31:0] a);
    return (sel != 0) ? m3.exists(a) : m0.exists(a);
  endfunction
  function automatic bit [7:0] mget(bit [31:0] a);
    if (!mhas(a)) return 8'h00;
    return (sel != 0) ? m3[a] : m0[a];
  endfunction

  function automatic bit legal(op_t o, int depth);
    int size = 1 << (o.f & 3);
    if (o.w ? (o.f > 3'd2) : !(o.f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 0;
    if ((o.a >> 2) >= depth) return 0;
    return (o.a % size) == 0;
  endfunction

  task automatic exec_model(op_t o);
    int size = 1 << (o.f & 3);
    longint v = 0;
    bit kn = 1;
    if (o.w) begin
      for (int i = 0; i < 4; i++)
        if (o.m[i]) begin
          if (sel != 0) m3[(o.a & ~32'd3) + i] = o.d[8*i +: 8];
          else          m0[(o.a & ~32'd3) + i] = o.d[8*i +: 8];
        end
    end else begin
      for (int i = 0; i < size; i++) begin
        kn &= mhas(o.a + i);
        v |= longint'(mget(o.a + i)) << (8*i);
      end
      if (!o.f[2] && size < 4 && v[8*size-1]) v -= (longint'(1) << (8*size));
      nxt_rv = 1; nxt_rd = v[31:0]; nxt_known = kn; rd_upd = 1;
    end
  endtask

  // Apply one cycle of stimulus, advance the model, then wait for mid-cycle
  task automatic drive(op_t o);
    int w = (sel != 0) ? 3 : 0;
    int depth = (sel != 0) ? D3 : D0;
    rst = o.r; cs0 = o.c && (sel == 0); cs3 = o.c && (sel != 0);
    we = o.w; wem = o.m; din = o.d; addr = o.a; f3 = o.f;
    cur_err = nxt_err; cur_rv = nxt_rv;
    if (rd_upd) begin cur_rd = nxt_rd; cur_known = nxt_known; end
    nxt_err = 0; nxt_rv = 0; rd_upd = 0; exp_hold = 0;
    if (o.r) begin
      pend = 0; rd_upd = 1; nxt_rd = 0; nxt_known = 1;
    end else begin
      if (pend && cyc < pexec) exp_hold = 1;
      else if (pend) begin exec_model(pop); pend = 0; end
      if (o.c && !pend) begin
        if (!legal(o, depth)) nxt_err = 1;
        else if (w == 0) exec_model(o);
        else begin pend = 1; pexec = cyc + w; pop = o; exp_hold = 1; end
      end
    end
    exp_o = {exp_hold, cur_err, cur_rv, cur_rd};
    care  = {!o.r, 1'b1, 1'b1, {32{cur_known}}};
    @(negedge clk);
  endtask

  task automatic step();
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic reset_to(int s);
    sel = s; rst = 1; cs0 = 0; cs3 = 0;
    step();
    pend = 0; nxt_err = 0; nxt_rv = 0; rd_upd = 1; nxt_rd = 0; nxt_known = 1;
  endtask

  task automatic test_reset();
    reset_to(0);
    drive(NOP());
    checks++;
    if ({h0, e0, rv0, rd0} !== 35'd0 || {h3, e3, rv3, rd3} !== 35'd0) begin
      errors++;
      $display("FAIL reset_state got u0=%h u3=%h exp 0", {h0, e0, rv0, rd0}, {h3, e3, rv3, rd3});
    end
    step();
  endtask

  task automatic test_basic();
    op_t q[$];
    reset_to(0);
    q = '{ST(32'h100, 32'hDEADBEEF, 4'hF, 3'd2), LD(32'h100, 3'd2), KC(NOP(), 32'hDEADBEEF),
          ST(32'h101, 32'h00008000, 4'b0010, 3'd0), LD(32'h101, 3'd0),
          KC(LD(32'h101, 3'd4), 32'hFFFFFF80), KC(LD(32'h100, 3'd2), 32'h00000080),
          KC(NOP(), 32'hDEAD80EF)};
    foreach (q[i]) begin
      drive(q[i]);
      checks++;
      if (((obs ^ exp_o) & care) !== '0) begin errors++; $display("FAIL basic[%0d] got=%h exp=%h", i, obs, exp_o); end
      if (q[i].kc) begin
        checks++;
        if (obs[32] !== 1'b1 || obs[31:0] !== q[i].kv) begin errors++; $display("FAIL basic_load[%0d] got rv=%b rd=%h exp rd=%h", i, obs[32], obs[31:0], q[i].kv); end
      end
      step();
    end
  endtask

  task automatic test_errors();
    op_t q[$];
    reset_to(0);
    q = '{LD(32'h102, 3'd2), KE(LD(32'h103, 3'd1)), KE(LD(32'h4000, 3'd2)), KE(ST(32'h102, 32'h0, 4'hF, 3'd2)),
          KE(LD(32'h100, 3'd3)), KE(ST(32'h100, 32'h0, 4'hF, 3'd4)), KE(ST(32'h100, 32'h0, 4'h0, 3'd2)),
          LD(32'h3FFC * 1, 3'd2), LD(32'h100, 3'd2), KC(NOP(), 32'hDEAD80EF)};
    foreach (q[i]) begin
      drive(q[i]);
      checks++;
      if (((obs ^ exp_o) & care) !== '0) begin errors++; $display("FAIL errors[%0d] got=%h exp=%h", i, obs, exp_o); end
      if (q[i].ke) begin
        checks++;
        if (obs[33] !== 1'b1 || obs[32] !== 1'b0) begin errors++; $display("FAIL errors_pulse[%0d] got err=%b rv=%b exp err=1 rv=0", i, obs[33], obs[32]); end
      end
      if (q[i].kc) begin
        checks++;
        if (obs[32] !== 1'b1 || obs[31:0] !== q[i].kv) begin errors++; $display("FAIL errors_ram[%0d] got rd=%h exp=%h", i, obs[31:0], q[i].kv); end
      end
      step();
    end
  endtask

  task automatic test_wait();
    op_t q[$];
    reset_to(1);
    q = '{ST(32'h200, 32'h80010000, 4'hF, 3'd2), NOP(), NOP(),
          KH(LD(32'h202, 3'd5)), KH(ST(32'h200, 32'hFFFFFFFF, 4'hF, 3'd2)), KH(NOP()),
          LD(32'h200, 3'd2), KC(NOP(), 32'h00008001), NOP(), NOP(), KC(NOP(), 32'h80010000),
          LD(32'h301, 3'd2), KE(LD(32'h400, 3'd2)), KE(NOP())};
    foreach (q[i]) begin
      drive(q[i]);
      checks++;
      if (((obs ^ exp_o) & care) !== '0) begin errors++; $display("FAIL wait[%0d] got=%h exp=%h", i, obs, exp_o); end
      if (q[i].kh) begin
        checks++;
        if (obs[34] !== 1'b1) begin errors++; $display("FAIL wait_hold[%0d] got=%b exp=1", i, obs[34]); end
      end
      if (q[i].kc) begin
        checks++;
        if (obs[32] !== 1'b1 || obs[31:0] !== q[i].kv) begin errors++; $display("FAIL wait_load[%0d] got rv=%b rd=%h exp rd=%h", i, obs[32], obs[31:0], q[i].kv); end
      end
      if (q[i].ke) begin
        checks++;
        if (obs[33] !== 1'b1 || obs[34] !== 1'b0) begin errors++; $display("FAIL wait_err[%0d] got err=%b hold=%b exp err=1 hold=0", i, obs[33], obs[34]); end
      end
      step();
    end
  endtask

  task automatic test_reset_busy();
    op_t q[$];
    reset_to(1);
    q = '{ST(32'h300, 32'hAAAA5555, 4'hF, 3'd2), NOP(), NOP(), NOP(),
          ST(32'h300, 32'h12345678, 4'hF, 3'd2), OP(1, 0, 0, 4'h0, 32'h0, 32'h0, 3'd0), KZ(NOP()),
          LD(32'h300, 3'd2), NOP(), NOP(), NOP(), KC(NOP(), 32'hAAAA5555),
          OP(1, 1, 1, 4'hF, 32'hBADBAD00, 32'h300, 3'd2), KZ(NOP()),
          LD(32'h300, 3'd2), NOP(), NOP(), NOP(), KC(NOP(), 32'hAAAA5555)};
    foreach (q[i]) begin
      drive(q[i]);
      checks++;
      if (((obs ^ exp_o) & care) !== '0) begin errors++; $display("FAIL rstbusy[%0d] got=%h exp=%h", i, obs, exp_o); end
      if (q[i].kz) begin
        checks++;
        if (obs !== 35'd0) begin errors++; $display("FAIL rstbusy_zero[%0d] got=%h exp=0", i, obs); end
      end
      if (q[i].kc) begin
        checks++;
        if (obs[32] !== 1'b1 || obs[31:0] !== q[i].kv) begin errors++; $display("FAIL rstbusy_load[%0d] got rd=%h exp=%h", i, obs[31:0], q[i].kv); end
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    op_t q[$];
    bit [31:0] d[4];
    op_t o;
    reset_to(0);
    for (int k = 0; k < 4; k++) begin
      d[k] = $urandom;
      o = ST(32'h400, d[k], 4'hF, 3'd2);
      if (k > 0) o = KC(o, d[k-1]);
      q.push_back(o);
      q.push_back(LD(32'h400, 3'd2));
    end
    q.push_back(KC(NOP(), d[3]));
    foreach (q[i]) begin
      drive(q[i]);
      checks++;
      if (((obs ^ exp_o) & care) !== '0) begin errors++; $display("FAIL b2b[%0d] got=%h exp=%h", i, obs, exp_o); end
      if (q[i].kc) begin
        checks++;
        if (obs[32] !== 1'b1 || obs[31:0] !== q[i].kv) begin errors++; $display("FAIL b2b_load[%0d] got rd=%h exp=%h", i, obs[31:0], q[i].kv); end
      end
      step();
    end
  endtask

  task automatic test_random(int s);
    op_t q[$];
    op_t o;
    int depth = (s != 0) ? D3 : D0;
    reset_to(s);
    for (int k = 0; k <= 32; k++) begin
      q.push_back(ST((k == 32) ? 32'(depth*4 - 4) : 32'(4*k), $urandom, 4'hF, 3'd2));
      if (s != 0) begin q.push_back(NOP()); q.push_back(NOP()); end
    end
    for (int k = 0; k < 250; k++) begin
      o = OP(0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 4'($urandom), $urandom, 32'($urandom_range(0, 127)), 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 3) != 0) o.f = o.w ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 1) ? $urandom_range(0, 2) : $urandom_range(4, 5));
      case ($urandom_range(0, 9))
        0: o.a = 32'(depth*4 + $urandom_range(0, 7));
        1: o.a = 32'(depth*4 - 4 + $urandom_range(0, 3));
        default: ;
      endcase
      o.r = ($urandom_range(0, 49) == 0);
      q.push_back(o);
    end
    repeat (5) q.push_back(NOP());
    foreach (q[i]) begin
      drive(q[i]);
      checks++;
      if (((obs ^ exp_o) & care) !== '0) begin errors++; $display("FAIL random%0d[%0d] got=%h exp=%h", s, i, obs, exp_o); end
      step();
    end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; sel = 0;
    rst = 1; cs0 = 0; cs3 = 0; we = 0; wem = 0; din = 0; addr = 0; f3 = 0;
    cur_known = 0; cur_rd = 0;
    test_reset();
    test_basic();
    test_errors();
    test_wait();
    test_reset_busy();
    test_back_to_back();
    test_random(0);
    test_random(1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
